// File: rtl/flash_rd_arb.sv
// flash_rd_arb: read arbiter and sequencer for the shared ASMI serial-flash read engine.
//
// Two requesters share one engine. Port A issues single-byte reads (Wishbone flash window),
// port B issues bursts of 1..256 bytes (boot/shadow-copy loader). Each port holds one
// pending request. The winner is chosen round-robin in IDLE. The block then runs the ASMI
// addr/rden/read handshake and steers data_valid bytes back to the owning port. Watchdog
// timers abort a transfer when the engine stalls.
//
// Ports:
//   wb_clk_i, wb_rst_n_i              clock, asynchronous active-low reset
//   a_start, a_addr                   port A request pulse and byte address
//   a_busy, a_dv, a_dat, a_done, a_err  port A status, read data and completion pulses
//   b_start, b_addr, b_len            port B request pulse, address, length-1
//   b_busy, b_dv, b_dat, b_done, b_err  port B status, read data and completion pulses
//   flash_addr, flash_rden, flash_read  ASMI address, read enable, read start pulse
//   flash_busy, flash_dv, flash_dout    ASMI busy, data_valid, dataout
// All outputs are registered.

module flash_rd_arb #(
   parameter int unsigned BUSY_TO = 16,
   parameter int unsigned DV_TO   = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   // port A: single-byte reads
   input  logic        a_start,
   input  logic [23:0] a_addr,
   output logic        a_busy,
   output logic        a_dv,
   output logic [7:0]  a_dat,
   output logic        a_done,
   output logic        a_err,
   // port B: burst reads
   input  logic        b_start,
   input  logic [23:0] b_addr,
   input  logic [7:0]  b_len,
   output logic        b_busy,
   output logic        b_dv,
   output logic [7:0]  b_dat,
   output logic        b_done,
   output logic        b_err,
   // ASMI engine
   output logic [23:0] flash_addr,
   output logic        flash_rden,
   output logic        flash_read,
   input  logic        flash_busy,
   input  logic        flash_dv,
   input  logic [7:0]  flash_dout
);

   localparam int unsigned TMax = (DV_TO > BUSY_TO) ? DV_TO : BUSY_TO;
   localparam int unsigned TW   = $clog2(TMax + 1);
   localparam logic [TW-1:0] BusyLim = TW'(BUSY_TO - 1);
   localparam logic [TW-1:0] DvLim   = TW'(DV_TO - 1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitB,
      StXfer,
      StDrain,
      StFin
   } state_t;

   state_t          state_q;
   logic            a_pend_q;
   logic            b_pend_q;
   logic [23:0]     a_addr_q;
   logic [23:0]     b_addr_q;
   logic [7:0]      b_len_q;
   logic            last_b_q;    // 1: port B was granted most recently
   logic            owner_b_q;   // 1: port B owns the current transfer
   logic            err_q;
   logic [8:0]      remaining_q;
   logic [TW-1:0]   timer_q;
   logic            grant_b;

   // B wins when it is the only one pending, or on a tie when A was served last.
   assign grant_b = b_pend_q & (~a_pend_q | ~last_b_q);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= StIdle;
         a_pend_q    <= 1'b0;
         b_pend_q    <= 1'b0;
         a_addr_q    <= '0;
         b_addr_q    <= '0;
         b_len_q     <= '0;
         last_b_q    <= 1'b1;
         owner_b_q   <= 1'b0;
         err_q       <= 1'b0;
         remaining_q <= '0;
         timer_q     <= '0;
         a_busy      <= 1'b0;
         a_dv        <= 1'b0;
         a_dat       <= '0;
         a_done      <= 1'b0;
         a_err       <= 1'b0;
         b_busy      <= 1'b0;
         b_dv        <= 1'b0;
         b_dat       <= '0;
         b_done      <= 1'b0;
         b_err       <= 1'b0;
         flash_addr  <= '0;
         flash_rden  <= 1'b0;
         flash_read  <= 1'b0;
      end else begin
         // single-cycle outputs
         a_dv       <= 1'b0;
         a_dat      <= '0;
         a_done     <= 1'b0;
         a_err      <= 1'b0;
         b_dv       <= 1'b0;
         b_dat      <= '0;
         b_done     <= 1'b0;
         b_err      <= 1'b0;
         flash_read <= 1'b0;

         // Pending slots: a start is only taken while the port is completely idle, so it can
         // never collide with the grant or the FIN clear of the same port.
         if (a_start && !a_busy) begin
            a_pend_q <= 1'b1;
            a_addr_q <= a_addr;
            a_busy   <= 1'b1;
         end
         if (b_start && !b_busy) begin
            b_pend_q <= 1'b1;
            b_addr_q <= b_addr;
            b_len_q  <= b_len;
            b_busy   <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (a_pend_q || b_pend_q) begin
                  owner_b_q <= grant_b;
                  err_q     <= 1'b0;
                  timer_q   <= '0;
                  state_q   <= StIssue;
                  if (grant_b) begin
                     b_pend_q    <= 1'b0;
                     flash_addr  <= b_addr_q;
                     remaining_q <= 9'(b_len_q) + 9'd1;
                  end else begin
                     a_pend_q    <= 1'b0;
                     flash_addr  <= a_addr_q;
                     remaining_q <= 9'd1;
                  end
               end
            end

            StIssue: begin
               flash_read <= 1'b1;
               flash_rden <= 1'b1;
               timer_q    <= '0;
               state_q    <= StWaitB;
            end

            StWaitB: begin
               if (flash_busy) begin
                  timer_q <= '0;
                  state_q <= StXfer;
               end else if (timer_q == BusyLim) begin
                  err_q      <= 1'b1;
                  flash_rden <= 1'b0;
                  timer_q    <= '0;
                  state_q    <= StDrain;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            StXfer: begin
               if (flash_dv) begin
                  if (owner_b_q) begin
                     b_dv  <= 1'b1;
                     b_dat <= flash_dout;
                  end else begin
                     a_dv  <= 1'b1;
                     a_dat <= flash_dout;
                  end
                  remaining_q <= remaining_q - 9'd1;
                  timer_q     <= '0;
                  if (remaining_q == 9'd1) begin
                     flash_rden <= 1'b0;
                     state_q    <= StDrain;
                  end
               end else if (timer_q == DvLim) begin
                  err_q      <= 1'b1;
                  flash_rden <= 1'b0;
                  timer_q    <= '0;
                  state_q    <= StDrain;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            StDrain: begin
               // late bytes from the engine are dropped here
               if (!flash_busy) begin
                  state_q <= StFin;
               end else if (timer_q == DvLim) begin
                  err_q   <= 1'b1;
                  state_q <= StFin;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            StFin: begin
               if (owner_b_q) begin
                  b_done <= ~err_q;
                  b_err  <= err_q;
                  b_busy <= 1'b0;
               end else begin
                  a_done <= ~err_q;
                  a_err  <= err_q;
                  a_busy <= 1'b0;
               end
               last_b_q <= owner_b_q;
               state_q  <= StIdle;
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/flash_rd_arb.md
# flash_rd_arb

Read arbiter and sequencer for the shared ASMI serial-flash read engine. Two requesters share the engine: port A is single-byte random reads from the Wishbone flash window, and port B is bulk burst reads from the boot/shadow-copy loader. The block queues one request per port, picks a winner round-robin, and drives the ASMI `addr`/`rden`/`read` handshake. It routes `data_valid` bytes back to the owner and recovers from a stuck engine using watchdog timers.

## Interface
Parameters:
- `BUSY_TO`, default 16: max cycles from read pulse to `flash_busy`=1 before abort.
- `DV_TO`, default 1024: max cycles between successive `flash_dv` pulses (and for `flash_busy` to fall) before abort.

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_n_i` in 1: asynchronous, active-low reset.
- `a_start` in 1: one-cycle pulse that queues a port A single-byte read.
- `a_addr` in 24: port A byte address, sampled with `a_start`.
- `a_busy` out 1: port A has a request pending or in service.
- `a_dv` out 1: pulse; `a_dat` is valid.
- `a_dat` out 8: read byte for port A.
- `a_done` out 1: pulse; port A request completed successfully.
- `a_err` out 1: pulse; port A request aborted by a watchdog.
- `b_start`, `b_addr` (24), `b_busy`, `b_dv`, `b_dat` (8), `b_done`, `b_err`: same as port A, for port B.
- `b_len` in 8: burst length minus 1, sampled with `b_start`, so 0 to 255 means 1 to 256 bytes.
- `flash_addr` out 24: ASMI byte address.
- `flash_rden` out 1: ASMI read enable.
- `flash_read` out 1: ASMI read start pulse.
- `flash_busy` in 1: ASMI busy.
- `flash_dv` in 1: ASMI data_valid.
- `flash_dout` in 8: ASMI dataout.

## Operation
Pending slots:
- `x_start` while `x_busy`=0 latches the address (and length for B) and sets the port's pending flag.
- `x_start` while `x_busy`=1 is ignored; the latched address is unchanged.
- Port A length is always 1.

Arbitration:
- Happens only in IDLE.
- If exactly one port is pending, that port wins.
- If both are pending, the port not granted last wins.
- `last` resets to B, so A wins the first tie.
- A grant clears the port's pending flag but keeps `x_busy` high until the port's done or err pulse.

FSM (states IDLE, ISSUE, WAITB, XFER, DRAIN, FIN):
- IDLE → ISSUE on a grant. Load `flash_addr`, and load `remaining` (9 bits) with 1 for A or `b_len`+1 for B.
- ISSUE: `flash_read`=1 and `flash_rden`=1 for one cycle, then → WAITB.
- WAITB: `flash_rden` held at 1.
  - → XFER when `flash_busy`=1.
  - Timer reaches BUSY_TO → DRAIN with the error flag set.
- XFER: `flash_rden` held at 1.
  - Each `flash_dv` forwards `flash_dout` to the owner's `x_dat`/`x_dv` and decrements `remaining`.
  - A `flash_dv` that brings `remaining` to 0 → DRAIN, with `flash_rden` low from the next cycle.
  - Timer is cleared on each `flash_dv`; reaching DV_TO → DRAIN with the error flag set.
- DRAIN: `flash_rden`=0.
  - Any `flash_dv` here is discarded and not forwarded.
  - → FIN when `flash_busy`=0 or the timer reaches DV_TO; reaching DV_TO also sets the error flag.
- FIN: one cycle.
  - Pulse the owner's `x_done` if the error flag is clear, else `x_err`. Never both.
  - Clear the owner's `x_busy`, set `last` to the owner, → IDLE.

Other rules:
- A port's start pulse in its own FIN cycle is ignored, because `x_busy` is still 1.
- A start from the other port is accepted in any state.
- `flash_addr` holds its value after the transfer.
- Data pulses go only to the owner; the other port's `dv`/`dat` stay at 0.

## Timing
- All outputs are registered.
- Reset (asynchronous, immediate) sets:
  - every output to 0;
  - FSM to IDLE;
  - pending flags, timers and error flag to 0;
  - `last` to B.
- A request already in flight when reset asserts is dropped with no done or err pulse.
- Latency from `x_start` at edge k (port idle, other port idle) to `flash_read` high: cycle k+2.
  - Edge k: latch the request.
  - Edge k+1: grant; the FSM enters ISSUE.
- `x_dv` is high in the cycle after the `flash_dv` it forwards (one-cycle pipeline).
- `x_done` or `x_err` is high in the cycle after DRAIN exits. The next grant can happen at the following edge.
- `remaining` is 9-bit, so `b_len`=255 gives 256 bytes with no wrap.
- `flash_addr` is 24-bit; address wrap inside the engine is the engine's concern.

## Test plan
1. `a_start` with `a_addr`=0x100000; model goes busy 3 cycles after the read pulse and returns 0x5A → `flash_addr`=0x100000, one `a_dv` with `a_dat`=0x5A, one `a_done`, `a_busy` low after FIN.
2. `b_start`, `b_addr`=0x010000, `b_len`=3; model streams 11,22,33,44,55 → four `b_dv` pulses (11..44), `flash_rden` low after the 4th, byte 55 discarded, one `b_done`.
3. `a_start` and `b_start` in the same cycle after reset → A served first, then B. Re-queue both during FIN of B → A served next; re-queue both during A's transfer → B wins.
4. Model never asserts busy → `a_err` 16 cycles after ISSUE plus the DRAIN exit; no `a_dv`. A new `a_start` afterwards is served normally.
5. `b_len`=255 burst with `wb_rst_n_i` pulsed low after byte 100 → all outputs immediately 0, no `b_done`/`b_err`, `b_busy`=0, FSM in IDLE.
6. `a_start` with 0x000200, then `a_start` with 0x000300 while `a_busy`=1 → only 0x000200 is read; one `a_done`.
